// File: rtl/rob_pkg.sv
// Shared encodings, per-entry status record and sizing helper for the reorder buffer.
// The wide payload (rd_reg, pc, data) lives in separate arrays sized by the instance parameters.
package rob_pkg;

  typedef enum logic [1:0] {
    TYPE_REG    = 2'b00,
    TYPE_BRANCH = 2'b01,
    TYPE_STORE  = 2'b10,
    TYPE_NONE   = 2'b11
  } inst_type_e;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mispredict;
    inst_type_e itype;
  } rob_status_t;

  function automatic int tag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rob_map_table.sv
// Architectural-register to youngest-producer-tag map with two lookup ports.
// The clear port only removes a mapping still owned by the retiring tag.
module rob_map_table
  import rob_pkg::*;
#(
  parameter int AREG_W = 5,
  parameter int TAG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AREG_W-1:0] rd_a_reg_i,
  output logic              rd_a_valid_o,
  output logic [TAG_W-1:0]  rd_a_tag_o,
  input  logic [AREG_W-1:0] rd_b_reg_i,
  output logic              rd_b_valid_o,
  output logic [TAG_W-1:0]  rd_b_tag_o,
  input  logic              wr_en_i,
  input  logic [AREG_W-1:0] wr_reg_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              clr_en_i,
  input  logic [AREG_W-1:0] clr_reg_i,
  input  logic [TAG_W-1:0]  clr_tag_i,
  input  logic              flush_i
);

  localparam int NREG = 1 << AREG_W;

  logic             valid_q [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];

  // Dispatch is applied after the retire clear so it wins on a shared register.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      for (int i = 0; i < NREG; i++) valid_q[i] <= 1'b0;
    end else begin
      if (clr_en_i && valid_q[clr_reg_i] && (tag_q[clr_reg_i] == clr_tag_i))
        valid_q[clr_reg_i] <= 1'b0;
      if (wr_en_i)
        valid_q[wr_reg_i] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i)
      tag_q[wr_reg_i] <= wr_tag_i;
  end

  assign rd_a_valid_o = valid_q[rd_a_reg_i];
  assign rd_a_tag_o   = tag_q[rd_a_reg_i];
  assign rd_b_valid_o = valid_q[rd_b_reg_i];
  assign rd_b_tag_o   = tag_q[rd_b_reg_i];

endmodule

// File: rtl/rob_ring.sv
// Circular reorder buffer: allocates tags at dispatch, captures CDB results and
// retires in program order, flushing everything on a mispredicted branch retire.
module rob_ring
  import rob_pkg::*;
#(
  parameter int  DEPTH  = 32,
  parameter int  DATA_W = 32,
  parameter int  PC_W   = 32,
  parameter int  AREG_W = 5,
  localparam int TAG_W  = tag_width(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [AREG_W-1:0] disp_rd_reg,
  input  logic [PC_W-1:0]   disp_pc,
  input  logic [1:0]        disp_type,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic [AREG_W-1:0] rs_reg,
  input  logic [AREG_W-1:0] rt_reg,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [TAG_W-1:0]  rs_tag,
  output logic [TAG_W-1:0]  rt_tag,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_data_valid,
  output logic              rt_data_valid,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic              store_commit_ready,
  output logic              retire_valid,
  output logic [TAG_W-1:0]  retire_tag,
  output logic [AREG_W-1:0] retire_rd_reg,
  output logic [DATA_W-1:0] retire_data,
  output logic [PC_W-1:0]   retire_pc,
  output logic [1:0]        retire_type,
  output logic              retire_mispredict,
  output logic              flush,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

  rob_status_t       status_q [DEPTH];
  logic [AREG_W-1:0] rd_q     [DEPTH];
  logic [PC_W-1:0]   pc_q     [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              retire_valid_q;
  logic [TAG_W-1:0]  retire_tag_q;
  logic [AREG_W-1:0] retire_rd_q;
  logic [DATA_W-1:0] retire_data_q;
  logic [PC_W-1:0]   retire_pc_q;
  logic [1:0]        retire_type_q;
  logic              retire_mis_q;
  logic              flush_q;

  rob_status_t       head_entry;
  logic              retire_fire;
  logic              flush_fire;
  logic              disp_fire;
  logic              cdb_hit;
  logic              map_a_valid, map_b_valid;
  logic [TAG_W-1:0]  map_a_tag, map_b_tag;

  // Fullness is judged on registered count, so a same-edge retire never frees a slot early.
  assign head_entry  = status_q[head_q];
  assign disp_ready  = (count_q != FULL_COUNT);
  assign retire_fire = head_entry.busy && head_entry.done &&
                       ((head_entry.itype != TYPE_STORE) || store_commit_ready);
  assign flush_fire  = retire_fire && head_entry.mispredict && (head_entry.itype == TYPE_BRANCH);
  assign disp_fire   = disp_valid && disp_ready && !flush_fire;
  assign cdb_hit     = cdb_valid && status_q[cdb_tag].busy;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_fire) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire_fire) head_d = head_q + TAG_ONE;
      if (disp_fire)   tail_d = tail_q + TAG_ONE;
      if (disp_fire && !retire_fire)
        count_d = count_q + CNT_ONE;
      else if (retire_fire && !disp_fire)
        count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) status_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (flush_fire) begin
        for (int i = 0; i < DEPTH; i++) status_q[i] <= '0;
      end else begin
        if (cdb_hit) begin
          status_q[cdb_tag].done       <= 1'b1;
          status_q[cdb_tag].mispredict <= cdb_mispredict;
        end
        if (retire_fire)
          status_q[head_q].busy <= 1'b0;
        if (disp_fire)
          status_q[tail_q] <= '{busy: 1'b1, done: 1'b0, mispredict: 1'b0,
                                itype: inst_type_e'(disp_type)};
      end
    end
  end

  // Payload arrays carry no reset; busy gates every use of them.
  always_ff @(posedge clock) begin
    if (disp_fire) begin
      rd_q[tail_q] <= disp_rd_reg;
      pc_q[tail_q] <= disp_pc;
    end
    if (cdb_hit)
      data_q[cdb_tag] <= cdb_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
      retire_rd_q    <= '0;
      retire_data_q  <= '0;
      retire_pc_q    <= '0;
      retire_type_q  <= '0;
      retire_mis_q   <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      retire_valid_q <= retire_fire;
      flush_q        <= flush_fire;
      if (retire_fire) begin
        retire_tag_q  <= head_q;
        retire_rd_q   <= rd_q[head_q];
        retire_data_q <= data_q[head_q];
        retire_pc_q   <= pc_q[head_q];
        retire_type_q <= head_entry.itype;
        retire_mis_q  <= head_entry.mispredict;
      end
    end
  end

  rob_map_table #(
    .AREG_W(AREG_W),
    .TAG_W (TAG_W)
  ) u_map (
    .clock       (clock),
    .reset       (reset),
    .rd_a_reg_i  (rs_reg),
    .rd_a_valid_o(map_a_valid),
    .rd_a_tag_o  (map_a_tag),
    .rd_b_reg_i  (rt_reg),
    .rd_b_valid_o(map_b_valid),
    .rd_b_tag_o  (map_b_tag),
    .wr_en_i     (disp_fire && (disp_type == TYPE_REG)),
    .wr_reg_i    (disp_rd_reg),
    .wr_tag_i    (tail_q),
    .clr_en_i    (retire_fire && (head_entry.itype == TYPE_REG)),
    .clr_reg_i   (rd_q[head_q]),
    .clr_tag_i   (head_q),
    .flush_i     (flush_fire)
  );

  assign rs_busy       = map_a_valid;
  assign rs_tag        = map_a_tag;
  assign rs_data       = data_q[map_a_tag];
  assign rs_data_valid = map_a_valid && status_q[map_a_tag].done;
  assign rt_busy       = map_b_valid;
  assign rt_tag        = map_b_tag;
  assign rt_data       = data_q[map_b_tag];
  assign rt_data_valid = map_b_valid && status_q[map_b_tag].done;

  assign disp_tag          = tail_q;
  assign count             = count_q;
  assign retire_valid      = retire_valid_q;
  assign retire_tag        = retire_tag_q;
  assign retire_rd_reg     = retire_rd_q;
  assign retire_data       = retire_data_q;
  assign retire_pc         = retire_pc_q;
  assign retire_type       = retire_type_q;
  assign retire_mispredict = retire_mis_q;
  assign flush             = flush_q;

endmodule
